// File: rtl/instr_mem_loader.sv
// Byte-stream loaded instruction store with big-endian word fetch.
// Optional CHECKSUM_EN adds a trailing checksum byte and err flag.
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_BITS      = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     load_len,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     cpu_rst_n,
  output logic [LEN_WIDTH-1:0]     byte_count,
  output logic                     err,
  input  logic [ADDRESS_WIDTH-1:0] A,
  output logic [ADDRESS_WIDTH-1:0] RD
);

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, LOAD, CHECK, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, DONE
  } state_t;
`endif

  localparam int DEPTH = 2 ** MEM_BITS;

  state_t state, state_d;
  logic   err_d;
  logic   xfer;
  logic   last;
  logic   accept;

  logic [LEN_WIDTH-1:0]  len;
  logic [MEM_BITS-1:0]   wr_ptr;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + 8'(in_data);
`endif

  assign xfer   = in_valid && in_ready;
  assign last   = (byte_count + LEN_WIDTH'(1)) == len;
  assign accept = start && (state == IDLE || state == DONE);

`ifdef CHECKSUM_EN
  assign in_ready = (state == LOAD) || (state == CHECK);
`else
  assign in_ready = (state == LOAD);
`endif
  assign busy = in_ready;
  assign done = (state == DONE);

  // Next-state and next-err decode
  always_comb begin
    state_d = state;
    err_d   = err;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = (load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (xfer && last) begin
`ifdef CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          state_d = DONE;
          err_d   = (sum_next != 8'h00);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered core reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
      len        <= '0;
      wr_ptr     <= '0;
      byte_count <= '0;
    end else begin
      state     <= state_d;
      err       <= err_d;
      cpu_rst_n <= (state_d == DONE) && !err_d;
      if (accept) begin
        len        <= load_len;
        wr_ptr     <= '0;
        byte_count <= '0;
      end else if (xfer && state == LOAD) begin
        wr_ptr     <= wr_ptr + MEM_BITS'(1);
        byte_count <= byte_count + LEN_WIDTH'(1);
      end
    end
  end

`ifdef CHECKSUM_EN
  // Running sum over data bytes and checksum byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (accept) begin
      sum <= '0;
    end else if (xfer) begin
      sum <= sum_next;
    end
  end
`endif

  // Image storage; contents survive reset
  always_ff @(posedge clk) begin
    if (xfer && state == LOAD) begin
      mem[wr_ptr] <= in_data;
    end
  end

  logic [MEM_BITS-1:0] a0, a1, a2, a3;
  logic                unused_a;

  assign a0 = A[MEM_BITS-1:0];
  assign a1 = a0 + MEM_BITS'(1);
  assign a2 = a0 + MEM_BITS'(2);
  assign a3 = a0 + MEM_BITS'(3);
  assign unused_a = ^A[ADDRESS_WIDTH-1:MEM_BITS];

  assign RD = ADDRESS_WIDTH'({mem[a0], mem[a1], mem[a2], mem[a3]});

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
// Checks load flow, wrap, reset mid-load and optional checksum.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        cpu_rst_n;
  logic [15:0] byte_count;
  logic        err;
  logic [31:0] A;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [8];

  instr_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .cpu_rst_n  (cpu_rst_n),
    .byte_count (byte_count),
    .err        (err),
    .A          (A),
    .RD         (RD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start    = 1'b1;
    load_len = n;
    step();
    start    = 1'b0;
    load_len = '0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    img[0] = 8'h13; img[1] = 8'h00;
    img[2] = 8'h50; img[3] = 8'h93;
    img[4] = 8'h00; img[5] = 8'h10;
    img[6] = 8'h01; img[7] = 8'h13;
    rst_n    = 1'b0;
    start    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    A        = '0;

    // reset and idle
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // back-to-back 8-byte load
    do_start(16'd8);
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = img[i];
      step();
    end
    in_valid = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_cpu", 32'(cpu_rst_n), 32'd1);
    chk("b2b_cnt", 32'(byte_count), 32'd8);
    chk("b2b_ready_off", 32'(in_ready), 32'd0);
    A = 32'd0; #1;
    chk("b2b_rd0", RD, 32'h13005093);
    A = 32'd4; #1;
    chk("b2b_rd4", RD, 32'h00100113);

    // same load with gaps; start pulsed mid-load
    do_start(16'd8);
    chk("gap_done_clr", 32'(done), 32'd0);
    chk("gap_cpu_clr", 32'(cpu_rst_n), 32'd0);
    chk("gap_cnt_clr", 32'(byte_count), 32'd0);
    begin
      int n;
      n = 0;
      for (int k = 0; k < 16; k++) begin
        in_valid = (k % 2 == 0);
        in_data  = img[k / 2];
        start    = (k == 5);
        load_len = '0;
        step();
        if (k % 2 == 0) n++;
        chk("gap_cnt", 32'(byte_count), 32'(n));
        chk("gap_done", 32'(done), 32'(n == 8));
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("gap_cpu", 32'(cpu_rst_n), 32'd1);

    // 258-byte load wraps the 256-byte store
    do_start(16'd258);
    for (int i = 0; i < 258; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i % 256);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_cnt", 32'(byte_count), 32'd258);
    chk("wrap_done", 32'(done), 32'd1);
    A = 32'd255; #1;
    chk("wrap_rd255", RD, 32'hFF000102);
    A = 32'd0; #1;
    chk("wrap_rd0", RD, 32'h00010203);

    // reset after 3 of 8 bytes
    do_start(16'd8);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk("mid_cpu", 32'(cpu_rst_n), 32'd0);
    chk("mid_cnt", 32'(byte_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cnt0", 32'(byte_count), 32'd0);
    chk("mid_cpu0", 32'(cpu_rst_n), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_idle_cpu", 32'(cpu_rst_n), 32'd0);
    chk("mid_idle_done", 32'(done), 32'd0);
    A = 32'd0; #1;
    chk("mid_retained", RD, 32'hAABBCC03);
    do_start(16'd4);
    send(8'h11);
    send(8'h22);
    chk("mid_cpu_ld", 32'(cpu_rst_n), 32'd0);
    send(8'h33);
    send(8'h44);
    chk("mid_new_cnt", 32'(byte_count), 32'd4);
    chk("mid_new_done", 32'(done), 32'd1);
    chk("mid_new_cpu", 32'(cpu_rst_n), 32'd1);
    A = 32'd0; #1;
    chk("mid_new_rd0", RD, 32'h11223344);
    A = 32'd4; #1;
    chk("mid_new_rd4", RD, 32'h04050607);

    // zero-length load goes straight to done
    do_start(16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cnt", 32'(byte_count), 32'd0);
    chk("zero_cpu", 32'(cpu_rst_n), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

`ifdef CHECKSUM_EN
    // good checksum
    do_start(16'd3);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("ck_check_ready", 32'(in_ready), 32'd1);
    chk("ck_check_done", 32'(done), 32'd0);
    chk("ck_check_cnt", 32'(byte_count), 32'd3);
    send(8'hFA);
    chk("ck_ok_done", 32'(done), 32'd1);
    chk("ck_ok_err", 32'(err), 32'd0);
    chk("ck_ok_cpu", 32'(cpu_rst_n), 32'd1);
    chk("ck_ok_cnt", 32'(byte_count), 32'd3);
    A = 32'd0; #1;
    chk("ck_ok_rd", RD, 32'h01020344);

    // bad checksum
    do_start(16'd3);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'hFB);
    chk("ck_bad_done", 32'(done), 32'd1);
    chk("ck_bad_err", 32'(err), 32'd1);
    chk("ck_bad_cpu", 32'(cpu_rst_n), 32'd0);

    // err clears on next accepted start
    do_start(16'd0);
    chk("ck_clr_err", 32'(err), 32'd0);
    chk("ck_clr_cpu", 32'(cpu_rst_n), 32'd1);
`else
    chk("nock_err", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writable byte-addressed instruction store with a byte-stream write port and a combinational big-endian word fetch port.
- Sits between the boot/debug byte source and the fetch stage.
- Holds the core in reset while an image is streamed in. Releases it once the programmed byte count has been written.

Parameters:
- ADDRESS_WIDTH, 32, width of fetch address A and instruction word RD
- DATA_WIDTH, 8, width of one memory byte and of in_data
- MEM_BITS, 8, memory depth is 2**MEM_BITS bytes
- LEN_WIDTH, 16, width of load_len and byte_count

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a load, sampled in IDLE and DONE only
- load_len  input  LEN_WIDTH  number of image bytes, latched when start is accepted
- in_valid  input  1  source has a byte on in_data
- in_data  input  DATA_WIDTH  image byte
- in_ready  output  1  loader accepts a byte this cycle
- busy  output  1  load in progress
- done  output  1  last load completed, held until the next accepted start
- cpu_rst_n  output  1  core reset, active-low, registered
- byte_count  output  LEN_WIDTH  bytes accepted in the current or last load
- err  output  1  checksum failure; constant 0 without CHECKSUM_EN
- A  input  ADDRESS_WIDTH  fetch byte address
- RD  output  ADDRESS_WIDTH  fetched instruction word

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=0, busy=0, done=0, cpu_rst_n=0, byte_count=0, err=0, wr_ptr=0.
  - Memory contents are not cleared.
- States: IDLE, LOAD, DONE; plus CHECK with CHECKSUM_EN.
- Output decode:
  - in_ready = (state==LOAD) or (state==CHECK).
  - busy = same as in_ready.
  - done = (state==DONE).
  - cpu_rst_n is registered: 1 only while state==DONE and err==0.
- IDLE/DONE, start=1 with load_len=0:
  - Enter DONE next cycle. byte_count=0, done=1, cpu_rst_n=1 from that edge.
- IDLE/DONE, start=1 with load_len>0:
  - Latch len, clear wr_ptr, byte_count and err, enter LOAD.
  - cpu_rst_n=0 and done=0 from the same edge.
- LOAD, byte transfer (in_valid & in_ready on a rising edge):
  - mem[wr_ptr mod 2**MEM_BITS] <= in_data; wr_ptr++, byte_count++.
  - On transfer number len, go to DONE, or to CHECK with CHECKSUM_EN.
- LOAD, other rules:
  - in_valid=0 leaves the state unchanged; there is no timeout.
  - start is ignored while in LOAD or CHECK.
- Throughput: one byte per cycle; zero-bubble back-to-back transfers.
- Address wrap: write address is wr_ptr modulo depth. len > 2**MEM_BITS overwrites earlier bytes in order, with no error.
- Fetch port:
  - RD = {mem[A], mem[A+1], mem[A+2], mem[A+3]}, indices modulo depth.
  - The byte at the lowest address goes to RD[31:24].
  - Purely combinational; no alignment check.
- Read during write: RD shows the old byte until the writing edge, the new byte afterward.
- Reset mid-load: immediate return to IDLE; bytes already written are retained; cpu_rst_n stays 0.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - After len data bytes, LOAD moves to CHECK and accepts exactly one extra byte. That byte is not written to memory and not counted in byte_count.
  - An 8-bit running sum covers all data bytes plus the checksum byte.
  - Sum == 8'h00: DONE with err=0, cpu_rst_n=1.
  - Sum != 8'h00: DONE with err=1 and cpu_rst_n held 0.
  - err clears on the next accepted start.
- Not defined: no CHECK state; err tied 0; DONE entered directly after the last data byte.

Test Plan:
- Reset then idle 5 cycles -> in_ready=0, busy=0, done=0, cpu_rst_n=0, byte_count=0.
- start with load_len=8, stream 13 00 50 93 00 10 01 13 back-to-back -> 8 cycles with in_ready=1, then done=1, cpu_rst_n=1. A=0 gives RD=32'h13005093; A=4 gives RD=32'h00100113.
- Same 8-byte load with in_valid toggled every other cycle -> byte_count steps only on transfers; done asserts after the 8th transfer; start pulsed mid-load is ignored.
- load_len=258 with MEM_BITS=8, bytes equal to index mod 256 -> bytes 256 and 257 overwrite addresses 0 and 1 (mem[0]=8'h00, mem[1]=8'h01). A=255 gives RD=32'hFF000102 (wraps to mem[0..2]).
- rst_n low after 3 of 8 bytes, release, start new load_len=4 -> IDLE, cpu_rst_n=0 throughout. Bytes 0-2 are retained until overwritten; new load completes with byte_count=4.
- CHECKSUM_EN: data 01 02 03 plus checksum FA -> err=0, cpu_rst_n=1. Same data plus checksum FB -> err=1, done=1, cpu_rst_n=0.
